// File: rtl/sm_switch_debounce_if.sv
// rtl/sm_switch_debounce_if.sv - switch debounce bundle: raw switch levels in, clean levels and strobes out
interface sm_switch_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             any_change;

    // master is the board/pin side, slave is the conditioning stage
    modport master (
        output sw_in,
        input  sw_out,
        input  sw_rise,
        input  sw_fall,
        input  any_change
    );

    modport slave (
        input  sw_in,
        output sw_out,
        output sw_rise,
        output sw_fall,
        output any_change
    );
endinterface

// File: rtl/sm_switch_debounce.sv
// rtl/sm_switch_debounce.sv - per-bit two-flop synchroniser and stability-counter debouncer with edge strobes
module sm_switch_debounce #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    sm_switch_debounce_if.slave sw_if
);

    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] sw_out_q;
    logic [WIDTH-1:0] sw_out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             any_q;
    logic             any_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A bit commits only after DEBOUNCE_CYCLES consecutive edges of disagreement;
    // any agreement in between clears its counter.
    always_comb begin
        sw_out_d = sw_out_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != sw_out_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_out_d[i] = sync2_q[i];
                    rise_d[i]   = sync2_q[i];
                    fall_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= RESET_VALUE;
            sync2_q  <= RESET_VALUE;
            sw_out_q <= RESET_VALUE;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sw_if.sw_in;
            sync2_q  <= sync1_q;
            sw_out_q <= sw_out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            any_q    <= any_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_if.sw_out     = sw_out_q;
    assign sw_if.sw_rise    = rise_q;
    assign sw_if.sw_fall    = fall_q;
    assign sw_if.any_change = any_q;

endmodule

// File: tb/tb_sm_switch_debounce.sv
// tb/tb_sm_switch_debounce.sv - directed and randomized bench for sm_switch_debounce
module tb_sm_switch_debounce;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #10 clk = ~clk;

    sm_switch_debounce_if #(.WIDTH(W)) sw_if ();

    sm_switch_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .RESET_VALUE    (8'h00)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw_if(sw_if)
    );

    // Reference: a bit flips once the last D synchronised samples all disagree with it.
    logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
    logic         m_any;
    logic [W-1:0] hist [$];

    task automatic model_edge();
        bit flip;
        if (!rst_n) begin
            m_s1 = 8'h00; m_s2 = 8'h00; m_out = 8'h00;
            m_rise = '0; m_fall = '0; m_any = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            if (hist.size() == D) begin
                for (int i = 0; i < W; i++) begin
                    flip = 1'b1;
                    for (int k = 0; k < D; k++)
                        if (hist[k][i] == m_out[i]) flip = 1'b0;
                    if (flip) begin
                        m_out[i] = ~m_out[i];
                        if (m_out[i]) m_rise[i] = 1'b1;
                        else          m_fall[i] = 1'b1;
                    end
                end
            end
            m_any = |(m_rise | m_fall);
            m_s2 = m_s1;
            m_s1 = sw_if.sw_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle(input logic [W-1:0] v);
        sw_if.sw_in = v;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        logic [W-1:0] eo, er;
        sw_if.sw_in = 8'hFF;
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if (sw_if.sw_out !== 8'h00 || sw_if.sw_rise !== 8'h00 || sw_if.sw_fall !== 8'h00 || sw_if.any_change !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: out=%h rise=%h fall=%h any=%b, required 00/00/00/0",
                     sw_if.sw_out, sw_if.sw_rise, sw_if.sw_fall, sw_if.any_change);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            eo = (e >= 6) ? 8'hFF : 8'h00;
            er = (e == 6) ? 8'hFF : 8'h00;
            vectors++;
            if (sw_if.sw_out !== eo || sw_if.sw_rise !== er || sw_if.any_change !== (e == 6)) begin
                miscompares++;
                $display("FAIL reset_release edge %0d: out=%h rise=%h any=%b, required %h/%h/%b",
                         e, sw_if.sw_out, sw_if.sw_rise, sw_if.any_change, eo, er, (e == 6));
            end
        end
    endtask

    task automatic test_glitch();
        settle(8'h00);
        for (int t = 0; t < 13; t++) begin
            sw_if.sw_in = (t < 3) ? 8'h01 : 8'h00;
            tick();
            vectors++;
            if (sw_if.sw_out[0] !== 1'b0 || sw_if.sw_rise[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch t=%0d: out0=%b rise0=%b, required 0/0", t, sw_if.sw_out[0], sw_if.sw_rise[0]);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        settle(8'h00);
        for (int t = 0; t < 4; t++) begin
            sw_if.sw_in[2] = (t % 2 == 0);
            tick();
            if (sw_if.sw_rise[2] === 1'b1) pulses++;
        end
        sw_if.sw_in[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (sw_if.sw_rise[2] === 1'b1) pulses++;
            vectors++;
            if (sw_if.sw_out[2] !== (e >= 6) || sw_if.sw_rise[2] !== (e == 6)) begin
                miscompares++;
                $display("FAIL bounce edge %0d: out2=%b rise2=%b, required %b/%b",
                         e, sw_if.sw_out[2], sw_if.sw_rise[2], (e >= 6), (e == 6));
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL bounce_pulses: %0d rise2 pulses, required 1", pulses);
        end
    endtask

    task automatic test_fall();
        logic [W-1:0] eo, ef;
        settle(8'h0F);
        sw_if.sw_in = 8'h0E;
        for (int e = 1; e <= 7; e++) begin
            tick();
            eo = (e >= 6) ? 8'h0E : 8'h0F;
            ef = (e == 6) ? 8'h01 : 8'h00;
            vectors++;
            if (sw_if.sw_out !== eo || sw_if.sw_fall !== ef || sw_if.sw_rise !== 8'h00) begin
                miscompares++;
                $display("FAIL fall edge %0d: out=%h fall=%h rise=%h, required %h/%h/00",
                         e, sw_if.sw_out, sw_if.sw_fall, sw_if.sw_rise, eo, ef);
            end
        end
    endtask

    task automatic test_simultaneous();
        int any_cycles = 0;
        int any_edge = 0;
        logic [W-1:0] seen = '0;
        settle(8'h00);
        sw_if.sw_in = 8'h81;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (sw_if.any_change === 1'b1) begin
                any_cycles++;
                any_edge = e;
                seen = sw_if.sw_rise;
            end
        end
        vectors++;
        if (any_cycles != 1 || any_edge != 6 || seen !== 8'h81) begin
            miscompares++;
            $display("FAIL simultaneous: any cycles=%0d edge=%0d rise=%h, required 1/6/81",
                     any_cycles, any_edge, seen);
        end
    endtask

    task automatic test_reset_midcount();
        settle(8'h00);
        sw_if.sw_in = 8'h20;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            vectors++;
            if (sw_if.sw_out[5] !== (e >= 6) || sw_if.sw_rise[5] !== (e == 6)) begin
                miscompares++;
                $display("FAIL reset_midcount edge %0d: out5=%b rise5=%b, required %b/%b",
                         e, sw_if.sw_out[5], sw_if.sw_rise[5], (e >= 6), (e == 6));
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 600; t++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            case ($urandom_range(0, 7))
                0: sw_if.sw_in = W'($urandom);
                1, 2: sw_if.sw_in = sw_if.sw_in ^ (8'h01 << $urandom_range(0, W - 1));
                default: ;
            endcase
            tick();
            vectors++;
            if (sw_if.sw_out !== m_out || sw_if.sw_rise !== m_rise || sw_if.sw_fall !== m_fall ||
                sw_if.any_change !== m_any || (sw_if.sw_rise & sw_if.sw_fall) !== 8'h00) begin
                miscompares++;
                $display("FAIL random t=%0d: out=%h rise=%h fall=%h any=%b, required %h/%h/%h/%b",
                         t, sw_if.sw_out, sw_if.sw_rise, sw_if.sw_fall, sw_if.any_change,
                         m_out, m_rise, m_fall, m_any);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        sw_if.sw_in = 8'h00;
        m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        test_reset();
        test_glitch();
        test_bounce();
        test_fall();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sm_switch_debounce.md
Name: sm_switch_debounce

Overview:
- Input conditioning stage placed between the raw LabFor board switches and sm_top.
- Synchronises each asynchronous switch bit to the 50 MHz clock and debounces it with an independent per-bit stability counter.
- Presents clean levels plus one-cycle rise/fall strobes.
- Downstream logic (rst_n, clkEnable, regAddr/ramAddr selection) takes its inputs from sw_out instead of the pins directly.

Parameters:
- WIDTH, 8: number of switch bits handled.
- DEBOUNCE_CYCLES, 1000000: consecutive stable clock cycles required to accept a new level; 20 ms at 50 MHz; must be >= 1.
- RESET_VALUE, 8'h00: WIDTH-bit value loaded into the synchroniser flops and sw_out on reset.

Ports:
- clk, input, 1: system clock, 50 MHz board clock.
- rst_n, input, 1: reset, synchronous, active-low.
- sw_in, input, WIDTH: raw asynchronous switch levels.
- sw_out, output, WIDTH: debounced switch levels.
- sw_rise, output, WIDTH: one-cycle pulse per bit when sw_out goes 0->1.
- sw_fall, output, WIDTH: one-cycle pulse per bit when sw_out goes 1->0.
- any_change, output, 1: OR-reduction of (sw_rise | sw_fall), registered alongside them.

Behaviour:
- Reset is synchronous and active-low: every register updates only on the rising edge of clk. With rst_n=0 at an edge:
  - sync1, sync2 and sw_out are set to RESET_VALUE.
  - All counters are set to 0.
  - sw_rise, sw_fall and any_change are set to 0.
- Synchroniser: a two-flop chain per bit, sw_in -> sync1 -> sync2. Only sync2 is used by the debounce logic.
- Counter: one per bit, width clog2(DEBOUNCE_CYCLES), minimum 1.
- Per-bit rule at each edge when not in reset:
  - sync2 == sw_out: cnt <= 0; no strobe.
  - sync2 != sw_out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1; sw_out holds.
  - sync2 != sw_out and cnt == DEBOUNCE_CYCLES-1: sw_out <= sync2, cnt <= 0, and the matching strobe (rise or fall) is asserted for exactly this one cycle.
- Latency: a pin change that is stable before edge k appears on sw_out, with its strobe, after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles. With DEBOUNCE_CYCLES=1 the latency is 3 cycles.
- Glitch rejection: any return of sync2 to sw_out before the count completes clears the counter. Pulses shorter than DEBOUNCE_CYCLES synchronised cycles never reach sw_out.
- Strobes:
  - sw_rise[i] and sw_fall[i] are never both 1.
  - Every strobe lasts exactly one cycle.
  - No strobe is generated by reset itself.
- Bits are fully independent. Simultaneous changes on several bits that each satisfy the rule commit on the same edge, with their strobes asserted together.
- Counter wrap-around is impossible by construction: the counter is cleared on commit and never exceeds DEBOUNCE_CYCLES-1.
- Reset mid-count discards the pending change. After rst_n returns high, the count restarts from 0 if sync2 still differs from RESET_VALUE.
- No combinational path from sw_in to any output. All outputs are driven directly by flops, except any_change, which is a flop loaded with the OR of the next-state strobes.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=8, RESET_VALUE=8'h00):
- Reset hold: rst_n=0 for 3 cycles with sw_in=8'hFF -> sw_out=8'h00, strobes=0. After release, sw_out=8'hFF on the 6th edge; sw_rise=8'hFF and any_change=1 for that one cycle only.
- Glitch: sw_in[0] high for 3 cycles then low -> sw_out[0] stays 0; no sw_rise[0] pulse.
- Bounce then settle: sw_in[2] toggles 1,0,1,0,1 on successive cycles, then is held 1 -> sw_out[2] rises exactly 6 edges after the last toggle; single sw_rise[2] pulse.
- Fall: with sw_out=8'h0F, sw_in changed to 8'h0E and held -> after 6 edges sw_out=8'h0E, sw_fall=8'h01, sw_rise=8'h00 for one cycle.
- Simultaneous: sw_in changes 8'h00->8'h81 in one cycle -> sw_rise=8'h81 on a single edge; any_change high for exactly 1 cycle.
- Reset mid-count: sw_in[5]=1 held; rst_n pulsed low for 1 cycle after 2 count cycles -> commit occurs 6 edges after rst_n returns high (sync chain reloads from RESET_VALUE), not earlier.
